frame_strobe_sequencer: RTL and testbench
=========================================

// Module: frame_strobe_sequencer
// PURPOSE
//   Configuration-side driver feeding one fabric column's FrameData/FrameStrobe daisy-chain (tiles buffer and forward both).
//   Accepts (frame index, frame word) pairs over valid/ready.
//   Per pair: holds the word stable on FrameData, then pulses exactly one FrameStrobe bit with setup/hold margins.
//   Sits between the bitstream loader and the column's top tile.
// PARAMETERS
//   MaxFramesPerCol  20  FrameStrobe width; valid frame indices 0..MaxFramesPerCol-1
//   FrameBitsPerRow  32  FrameData width
//   SETUP_CYCLES      1  cycles FrameData is stable before strobe rises (>=1)
//   STROBE_CYCLES     2  cycles strobe bit stays high (>=1)
//   HOLD_CYCLES       1  cycles FrameData is held after strobe falls (>=0)
//   IDX_W             5  cfg_frame width, >= clog2(MaxFramesPerCol)
// PORTS
//   UserCLK      in   1                single clock, all logic rising-edge
//   Reset        in   1                synchronous, active-high
//   cfg_valid    in   1                request valid
//   cfg_ready    out  1                request accepted when valid&ready
//   cfg_frame    in   IDX_W            target frame index
//   cfg_data     in   FrameBitsPerRow  frame word
//   cfg_parity   in   1                even parity of cfg_data (only with FRAME_PARITY_CHECK_EN)
//   err_clr      in   1                clears err
//   FrameData    out  FrameBitsPerRow  registered frame word to column
//   FrameStrobe  out  MaxFramesPerCol  registered one-hot/zero strobe
//   busy         out  1                high in any state except IDLE
//   done         out  1                1-cycle pulse: a frame write completed
//   err          out  1                sticky error flag
// BEHAVIOUR
//   Reset (sync): state=IDLE, FrameData=0, FrameStrobe=0, done=0, err=0, busy=0.
//   cfg_ready = (state==IDLE) & ~Reset; combinational from state only, never from cfg_valid.
//   FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. One down-counter, loaded on each state entry.
//   IDLE: on accept with cfg_frame < MaxFramesPerCol:
//     FrameData <= cfg_data; latch index; enter SETUP.
//   SETUP: SETUP_CYCLES cycles, FrameStrobe=0; then STROBE.
//   STROBE: FrameStrobe[idx]=1, all other bits 0, exactly STROBE_CYCLES cycles.
//     Strobe rises on the edge after the last SETUP cycle.
//   HOLD: HOLD_CYCLES cycles, FrameStrobe=0. HOLD_CYCLES=0 -> STROBE goes straight to IDLE.
//   done=1 in the first IDLE cycle after a write, i.e. together with cfg_ready=1.
//   Back-to-back writes are allowed; done and the next acceptance may coincide.
//   Min accept-to-accept spacing: 1+SETUP+STROBE+HOLD cycles (5 with defaults).
//   FrameData holds its last value in IDLE until the next valid acceptance; it never changes outside IDLE->SETUP.
//   Out-of-range index (cfg_frame >= MaxFramesPerCol):
//     handshake completes; err<=1; FrameData unchanged; no strobe; no done; stays IDLE (ready next cycle).
//   err: sticky. err_clr clears it; a new error in the same cycle as err_clr wins (err stays 1).
//   Reset mid-operation: next edge FrameStrobe=0, FrameData=0, IDLE, no done. The aborted write is lost.
//   cfg_* are ignored when not IDLE; the upstream stage holds them stable until accepted.
// CONFIGURATION
//   FRAME_PARITY_CHECK_EN defined:
//     on accept, ^cfg_data must equal cfg_parity.
//     Mismatch is treated like a bad index: err<=1, no strobe, no done.
//   FRAME_PARITY_CHECK_EN undefined:
//     cfg_parity port is absent; no parity check.
// TESTING
//   1. Reset, write frame 3, data 0xDEADBEEF, defaults:
//      FrameData=0xDEADBEEF one cycle after accept; FrameStrobe=0x00008 for 2 cycles starting accept+2;
//      done at accept+5; FrameData stays 0xDEADBEEF.
//   2. Back-to-back frame 0 (0x1) then frame 19 (0x2), cfg_valid held high:
//      second accept coincides with first done; strobes 0x00001 then 0x80000; never two bits set at once.
//   3. cfg_frame=20:
//      err=1, FrameStrobe stays 0, FrameData unchanged, no done.
//      err_clr alone -> err=0; err_clr together with a new bad index -> err stays 1.
//   4. Assert Reset during STROBE of frame 5:
//      next edge FrameStrobe=0, FrameData=0, busy=0, no done; cfg_ready=1 after Reset drops.
//   5. HOLD_CYCLES=0, STROBE_CYCLES=1, SETUP_CYCLES=3:
//      strobe at accept+4 for 1 cycle; done at accept+5.
//   6. With FRAME_PARITY_CHECK_EN, data 0x00000001 and cfg_parity=0:
//      err=1, no strobe. Same data with cfg_parity=1: normal write and done.

Source files
------------

// File: rtl/frame_strobe_sequencer_if.sv
// Configuration request channel (frame index + frame word) between the bitstream loader and the sequencer.
// The cfg_parity wire exists only when FRAME_PARITY_CHECK_EN is defined.
interface frame_strobe_sequencer_if #(
  parameter int IDX_W           = 5,
  parameter int FrameBitsPerRow = 32
) ();
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [IDX_W-1:0]           cfg_frame;
  logic [FrameBitsPerRow-1:0] cfg_data;
`ifdef FRAME_PARITY_CHECK_EN
  logic                       cfg_parity;
`endif

  modport master (
`ifdef FRAME_PARITY_CHECK_EN
    output cfg_parity,
`endif
    output cfg_valid, cfg_frame, cfg_data,
    input  cfg_ready
  );

  modport slave (
`ifdef FRAME_PARITY_CHECK_EN
    input  cfg_parity,
`endif
    input  cfg_valid, cfg_frame, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// Drives one column's FrameData/FrameStrobe chain: word setup, single one-hot strobe pulse, hold.
// Optional FRAME_PARITY_CHECK_EN rejects words whose even parity disagrees with cfg_parity.
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int IDX_W           = 5
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  frame_strobe_sequencer_if.slave    cfg,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int MAX_SU = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_C  = (MAX_SU > HOLD_CYCLES) ? MAX_SU : HOLD_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  // Counter is loaded with N-1 and the state advances when it reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       accept, bad_req;

  assign cfg.cfg_ready = (state_q == IDLE) & ~Reset;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

`ifdef FRAME_PARITY_CHECK_EN
  assign bad_req = (32'(cfg.cfg_frame) >= 32'(MaxFramesPerCol)) |
                   ((^cfg.cfg_data) != cfg.cfg_parity);
`else
  assign bad_req = (32'(cfg.cfg_frame) >= 32'(MaxFramesPerCol));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    done_d   = 1'b0;
    err_d    = err_q;
    // A fresh error overrides a simultaneous clear.
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            data_d  = cfg.cfg_data;
            idx_d   = cfg.cfg_frame;
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d  = STROBE;
          cnt_d    = STROBE_LD;
          strobe_d = MaxFramesPerCol'(1) << idx_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          strobe_d = '0;
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench: default-timing DUT (a) plus a SETUP=3/STROBE=1/HOLD=0 DUT (b).
// Parity scenario runs only when FRAME_PARITY_CHECK_EN is defined.
module tb_frame_strobe_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  frame_strobe_sequencer_if #(.IDX_W(5), .FrameBitsPerRow(32)) ifa ();
  frame_strobe_sequencer_if #(.IDX_W(5), .FrameBitsPerRow(32)) ifb ();

  logic        a_err_clr, b_err_clr;
  logic [31:0] a_fd, b_fd;
  logic [19:0] a_fs, b_fs;
  logic        a_busy, a_done, a_err, b_busy, b_done, b_err;

  frame_strobe_sequencer dut_a (
    .UserCLK(clk), .Reset(rst), .cfg(ifa.slave), .err_clr(a_err_clr),
    .FrameData(a_fd), .FrameStrobe(a_fs), .busy(a_busy), .done(a_done), .err(a_err)
  );

  frame_strobe_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(0)) dut_b (
    .UserCLK(clk), .Reset(rst), .cfg(ifb.slave), .err_clr(b_err_clr),
    .FrameData(b_fd), .FrameStrobe(b_fs), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] frame, input logic [31:0] data);
    ifa.cfg_valid = 1'b1;
    ifa.cfg_frame = frame;
    ifa.cfg_data  = data;
`ifdef FRAME_PARITY_CHECK_EN
    ifa.cfg_parity = ^data;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (a_fd !== 32'h0)  begin bad++; $display("FAIL reset_fd: got %h want 0", a_fd); end
    total++; if (a_fs !== 20'h0)  begin bad++; $display("FAIL reset_fs: got %h want 0", a_fs); end
    total++; if ({a_busy, a_done, a_err} !== 3'b000)
      begin bad++; $display("FAIL reset_flags: got %b want 000", {a_busy, a_done, a_err}); end
    total++; if (ifa.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_hi: got %b want 0", ifa.cfg_ready); end
    rst = 1'b0;
    #1;
    total++; if (ifa.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_lo: got %b want 1", ifa.cfg_ready); end
  endtask

  task automatic test_single_write();
    logic [19:0] exp_fs [1:6] = '{20'h0, 20'h8, 20'h8, 20'h0, 20'h0, 20'h0};
    logic        exp_dn [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_by [1:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive_a(5'd3, 32'hDEADBEEF);
    step();
    ifa.cfg_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      total++; if (a_fd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_fd c%0d: got %h want deadbeef", k, a_fd); end
      total++; if (a_fs !== exp_fs[k]) begin bad++; $display("FAIL single_fs c%0d: got %h want %h", k, a_fs, exp_fs[k]); end
      total++; if (a_done !== exp_dn[k]) begin bad++; $display("FAIL single_done c%0d: got %b want %b", k, a_done, exp_dn[k]); end
      total++; if (a_busy !== exp_by[k]) begin bad++; $display("FAIL single_busy c%0d: got %b want %b", k, a_busy, exp_by[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_fs [1:10] = '{20'h0, 20'h1, 20'h1, 20'h0, 20'h0,
                                   20'h0, 20'h80000, 20'h80000, 20'h0, 20'h0};
    logic        exp_dn [1:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_fd;
    drive_a(5'd0, 32'h1);
    step();
    drive_a(5'd19, 32'h2);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) step();
      if (k == 6) ifa.cfg_valid = 1'b0;
      exp_fd = (k <= 5) ? 32'h1 : 32'h2;
      total++; if (a_fd !== exp_fd) begin bad++; $display("FAIL b2b_fd c%0d: got %h want %h", k, a_fd, exp_fd); end
      total++; if (a_fs !== exp_fs[k]) begin bad++; $display("FAIL b2b_fs c%0d: got %h want %h", k, a_fs, exp_fs[k]); end
      total++; if (a_done !== exp_dn[k]) begin bad++; $display("FAIL b2b_done c%0d: got %b want %b", k, a_done, exp_dn[k]); end
      if (k == 5) begin
        total++; if (ifa.cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready c5: got %b want 1", ifa.cfg_ready); end
      end
    end
  endtask

  task automatic test_bad_index();
    drive_a(5'd20, 32'h55);
    step();
    ifa.cfg_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      total++; if (a_err !== 1'b1) begin bad++; $display("FAIL bad_err c%0d: got %b want 1", k, a_err); end
      total++; if (a_fs !== 20'h0) begin bad++; $display("FAIL bad_fs c%0d: got %h want 0", k, a_fs); end
      total++; if (a_fd !== 32'h2) begin bad++; $display("FAIL bad_fd c%0d: got %h want 2", k, a_fd); end
      total++; if ({a_done, a_busy, ifa.cfg_ready} !== 3'b001)
        begin bad++; $display("FAIL bad_flags c%0d: got %b want 001", k, {a_done, a_busy, ifa.cfg_ready}); end
    end
    a_err_clr = 1'b1;
    step();
    a_err_clr = 1'b0;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL bad_clr: got %b want 0", a_err); end
    step();
    drive_a(5'd20, 32'h55);
    step();
    ifa.cfg_valid = 1'b0;
    a_err_clr = 1'b1;
    drive_a(5'd31, 32'h66);
    step();
    ifa.cfg_valid = 1'b0;
    a_err_clr = 1'b0;
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL bad_clr_vs_err: got %b want 1", a_err); end
    step();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL bad_sticky: got %b want 1", a_err); end
    a_err_clr = 1'b1;
    step();
    a_err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_a(5'd5, 32'hA5A5A5A5);
    step();
    ifa.cfg_valid = 1'b0;
    step();
    total++; if (a_fs !== 20'h20) begin bad++; $display("FAIL mid_strobe: got %h want 00020", a_fs); end
    rst = 1'b1;
    step();
    total++; if (a_fs !== 20'h0) begin bad++; $display("FAIL mid_fs: got %h want 0", a_fs); end
    total++; if (a_fd !== 32'h0) begin bad++; $display("FAIL mid_fd: got %h want 0", a_fd); end
    total++; if ({a_busy, a_done} !== 2'b00) begin bad++; $display("FAIL mid_flags: got %b want 00", {a_busy, a_done}); end
    rst = 1'b0;
    #1;
    total++; if (ifa.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", ifa.cfg_ready); end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if ({a_done, a_fs} !== 21'h0) begin bad++; $display("FAIL mid_nodone c%0d: got %h want 0", k, {a_done, a_fs}); end
    end
  endtask

  task automatic test_short_timing();
    logic [19:0] exp_fs [1:6] = '{20'h0, 20'h0, 20'h0, 20'h80, 20'h0, 20'h0};
    logic        exp_dn [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_by [1:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ifb.cfg_valid = 1'b1;
    ifb.cfg_frame = 5'd7;
    ifb.cfg_data  = 32'h77;
`ifdef FRAME_PARITY_CHECK_EN
    ifb.cfg_parity = ^32'h77;
`endif
    step();
    ifb.cfg_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      total++; if (b_fs !== exp_fs[k]) begin bad++; $display("FAIL short_fs c%0d: got %h want %h", k, b_fs, exp_fs[k]); end
      total++; if (b_done !== exp_dn[k]) begin bad++; $display("FAIL short_done c%0d: got %b want %b", k, b_done, exp_dn[k]); end
      total++; if (b_busy !== exp_by[k]) begin bad++; $display("FAIL short_busy c%0d: got %b want %b", k, b_busy, exp_by[k]); end
    end
    total++; if (b_fd !== 32'h77) begin bad++; $display("FAIL short_fd: got %h want 77", b_fd); end
  endtask

`ifdef FRAME_PARITY_CHECK_EN
  task automatic test_parity();
    drive_a(5'd2, 32'h1);
    ifa.cfg_parity = 1'b0;
    step();
    ifa.cfg_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      total++; if (a_err !== 1'b1) begin bad++; $display("FAIL par_err c%0d: got %b want 1", k, a_err); end
      total++; if ({a_fs, a_done, a_busy} !== 22'h0)
        begin bad++; $display("FAIL par_idle c%0d: got %h want 0", k, {a_fs, a_done, a_busy}); end
    end
    a_err_clr = 1'b1;
    step();
    a_err_clr = 1'b0;
    drive_a(5'd2, 32'h1);
    ifa.cfg_parity = 1'b1;
    step();
    ifa.cfg_valid = 1'b0;
    step();
    total++; if (a_fs !== 20'h4) begin bad++; $display("FAIL par_strobe: got %h want 00004", a_fs); end
    step(); step(); step();
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL par_done: got %b want 1", a_done); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL par_noerr: got %b want 0", a_err); end
  endtask
`endif

  initial begin
    ifa.cfg_valid = 1'b0; ifa.cfg_frame = '0; ifa.cfg_data = '0;
    ifb.cfg_valid = 1'b0; ifb.cfg_frame = '0; ifb.cfg_data = '0;
`ifdef FRAME_PARITY_CHECK_EN
    ifa.cfg_parity = 1'b0;
    ifb.cfg_parity = 1'b0;
`endif
    a_err_clr = 1'b0;
    b_err_clr = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_bad_index();
    test_reset_mid();
    test_short_timing();
`ifdef FRAME_PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
